// File: rtl/zigzag_rle.sv
// zigzag_rle: ping-pong 8x8 coefficient buffer with a zigzag scanner that
// emits JPEG-style (run, level) symbols terminated by one EOB per block.
// Optional build macro ZZ_RLE_ZRL_EN: split runs over 15 into (15,0) ZRL
// symbols so rle_run never exceeds 15.
module zigzag_rle (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] dctq,
  input  logic       dctq_valid,
  input  logic [5:0] addr,
  output logic       hold,
  output logic [5:0] rle_run,
  output logic [8:0] rle_level,
  output logic       rle_eob,
  output logic       rle_valid,
  input  logic       rle_ready,
  output logic       overflow
);

  // Zigzag index -> raster address.
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  typedef enum logic [1:0] {IDLE, SCAN, EOB} state_t;

  state_t     state;
  logic [8:0] mem [128];   // {bank, raster addr}
  logic [1:0] full;
  logic       wr_bank, rd_bank, eob_sent;
  logic [5:0] k, run;
  logic [8:0] cur;
  logic       wr_en, out_free, accept;

  // The write bank is full only when the other bank is still occupied.
  assign hold     = full[wr_bank];
  assign wr_en    = dctq_valid && !hold;
  assign cur      = mem[{rd_bank, ZZ[k]}];
  assign out_free = !rle_valid || rle_ready;
  assign accept   = rle_valid && rle_ready;

  // Coefficient storage; contents are not reset, only the full flags are.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, addr}] <= dctq;
  end

  // Write pointer swap on block completion and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && addr == 6'd63) wr_bank <= ~wr_bank;
      if (dctq_valid && hold)     overflow <= 1'b1;
    end
  end

  // Scan FSM: owns bank full flags, run counter and the output symbol register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      full      <= 2'b00;
      rd_bank   <= 1'b0;
      eob_sent  <= 1'b0;
      k         <= 6'd0;
      run       <= 6'd0;
      rle_valid <= 1'b0;
      rle_run   <= 6'd0;
      rle_level <= 9'd0;
      rle_eob   <= 1'b0;
    end else begin
      if (accept) rle_valid <= 1'b0;
      if (wr_en && addr == 6'd63) full[wr_bank] <= 1'b1;
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            state <= SCAN;
            k     <= 6'd0;
            run   <= 6'd0;
          end
        end
        SCAN: begin
          if (out_free) begin
            if (k == 6'd0 || cur != 9'd0) begin
`ifdef ZZ_RLE_ZRL_EN
              if (run > 6'd15) begin
                // Emit one ZRL and hold k until the residual run fits.
                rle_valid <= 1'b1;
                rle_run   <= 6'd15;
                rle_level <= 9'd0;
                rle_eob   <= 1'b0;
                run       <= run - 6'd16;
              end else
`endif
              begin
                rle_valid <= 1'b1;
                rle_run   <= run;
                rle_level <= cur;
                rle_eob   <= 1'b0;
                run       <= 6'd0;
                if (k == 6'd63) state <= EOB;
                else            k     <= k + 6'd1;
              end
            end else begin
              run <= run + 6'd1;
              if (k == 6'd63) state <= EOB;
              else            k     <= k + 6'd1;
            end
          end
        end
        EOB: begin
          if (!eob_sent) begin
            if (out_free) begin
              rle_valid <= 1'b1;
              rle_run   <= 6'd0;
              rle_level <= 9'd0;
              rle_eob   <= 1'b1;
              eob_sent  <= 1'b1;
            end
          end else if (accept) begin
            // Bank is released only once the EOB has been taken downstream.
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            eob_sent      <= 1'b0;
            if (full[~rd_bank]) begin
              state <= SCAN;
              k     <= 6'd0;
              run   <= 6'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_rle.sv
// Directed bench for zigzag_rle: latency, symbol streams, back-pressure,
// stall stability, overflow and mid-block reset.
module tb_zigzag_rle;

  logic       clk = 1'b0;
  logic       reset, dctq_valid, rle_ready;
  logic [8:0] dctq;
  logic [5:0] addr;
  logic       hold, rle_eob, rle_valid, overflow;
  logic [5:0] rle_run;
  logic [8:0] rle_level;

  int tests = 0;
  int fails = 0;

  logic [15:0] q   [$];   // accepted symbols {eob, run, level}
  logic [15:0] exp [$];
  logic [8:0]  blk [64];

  always #5 clk = ~clk;

  zigzag_rle dut (
    .clk(clk), .reset(reset), .dctq(dctq), .dctq_valid(dctq_valid),
    .addr(addr), .hold(hold), .rle_run(rle_run), .rle_level(rle_level),
    .rle_eob(rle_eob), .rle_valid(rle_valid), .rle_ready(rle_ready),
    .overflow(overflow)
  );

  logic [18:0] outs;
  assign outs = {hold, rle_valid, rle_eob, overflow, rle_run, rle_level};

  // Record each symbol that will be accepted at the coming rising edge.
  always @(negedge clk)
    if (!reset && rle_valid && rle_ready) q.push_back({rle_eob, rle_run, rle_level});

  function automatic logic [15:0] sym(input logic e, input logic [5:0] r, input logic [8:0] l);
    return {e, r, l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 9'd0;
  endtask

  task automatic send_block();
    for (int a = 0; a < 64; a++) begin
      dctq_valid = 1'b1;
      addr       = 6'(a);
      dctq       = blk[a];
      tick();
    end
    dctq_valid = 1'b0;
  endtask

  task automatic wait_syms(input int n);
    for (int c = 0; c < 3000 && q.size() < n; c++) tick();
    repeat (8) tick();
  endtask

  // Expected stream for a block with DC and raster 63 nonzero only.
  task automatic exp_dc63(input logic [8:0] dc, input logic [8:0] last);
    exp.push_back(sym(1'b0, 6'd0, dc));
`ifdef ZZ_RLE_ZRL_EN
    repeat (3) exp.push_back(sym(1'b0, 6'd15, 9'd0));
    exp.push_back(sym(1'b0, 6'd14, last));
`else
    exp.push_back(sym(1'b0, 6'd62, last));
`endif
    exp.push_back(sym(1'b1, 6'd0, 9'd0));
  endtask

  task automatic test_reset();
    reset = 1'b1; dctq_valid = 1'b0; rle_ready = 1'b0; addr = 6'd0; dctq = 9'd0;
    repeat (3) tick();
    tests++;
    if (outs !== 19'd0) begin fails++; $display("FAIL reset_outs: got %h expected 0", outs); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_all_zero();
    rle_ready = 1'b1; q.delete(); exp.delete();
    clear_blk(); send_block();
    tests++;
    if (rle_valid !== 1'b0) begin fails++; $display("FAIL lat_edge0: got %b expected 0", rle_valid); end
    tick();
    tests++;
    if (rle_valid !== 1'b0) begin fails++; $display("FAIL lat_edge1: got %b expected 0", rle_valid); end
    tick();
    tests++;
    if ({rle_valid, rle_eob, rle_run, rle_level} !== {1'b1, 1'b0, 6'd0, 9'd0}) begin
      fails++; $display("FAIL lat_edge2_dc: got v=%b e=%b r=%0d l=%h expected v=1 e=0 r=0 l=000",
                        rle_valid, rle_eob, rle_run, rle_level);
    end
    wait_syms(2);
    exp.push_back(sym(1'b0, 6'd0, 9'd0));
    exp.push_back(sym(1'b1, 6'd0, 9'd0));
    tests++;
    if (q.size() !== exp.size()) begin fails++; $display("FAIL zero_count: got %0d expected %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++;
      if (q[i] !== exp[i]) begin fails++; $display("FAIL zero_sym%0d: got %h expected %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_dc63();
    rle_ready = 1'b1; q.delete(); exp.delete();
    clear_blk(); blk[0] = 9'd10; blk[63] = 9'd5;
    send_block(); wait_syms(6);
    exp_dc63(9'd10, 9'd5);
    tests++;
    if (q.size() !== exp.size()) begin fails++; $display("FAIL dc63_count: got %0d expected %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++;
      if (q[i] !== exp[i]) begin fails++; $display("FAIL dc63_sym%0d: got %h expected %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_negative();
    rle_ready = 1'b1; q.delete(); exp.delete();
    clear_blk(); blk[1] = 9'h1FF; blk[8] = 9'd3;
    send_block(); wait_syms(4);
    exp.push_back(sym(1'b0, 6'd0, 9'd0));
    exp.push_back(sym(1'b0, 6'd0, 9'h1FF));
    exp.push_back(sym(1'b0, 6'd0, 9'd3));
    exp.push_back(sym(1'b1, 6'd0, 9'd0));
    tests++;
    if (q.size() !== exp.size()) begin fails++; $display("FAIL neg_count: got %0d expected %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++;
      if (q[i] !== exp[i]) begin fails++; $display("FAIL neg_sym%0d: got %h expected %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    rle_ready = 1'b0; q.delete(); exp.delete();
    clear_blk(); blk[0] = 9'd1; send_block();
    tests++;
    if (hold !== 1'b0) begin fails++; $display("FAIL b2b_hold_b1: got %b expected 0", hold); end
    clear_blk(); blk[0] = 9'd2; blk[63] = 9'd7; send_block();
    tests++;
    if (hold !== 1'b1) begin fails++; $display("FAIL b2b_hold_b2: got %b expected 1", hold); end
    for (int i = 0; i < 5; i++) begin
      dctq_valid = 1'b1; addr = 6'(i); dctq = 9'h055; tick();
    end
    dctq_valid = 1'b0;
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL b2b_overflow: got %b expected 1", overflow); end
    tests++;
    if (q.size() !== 0) begin fails++; $display("FAIL b2b_no_accept: got %0d expected 0", q.size()); end
    rle_ready = 1'b1;
    wait_syms(7);
    exp.push_back(sym(1'b0, 6'd0, 9'd1));
    exp.push_back(sym(1'b1, 6'd0, 9'd0));
    exp_dc63(9'd2, 9'd7);
    tests++;
    if (q.size() !== exp.size()) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++;
      if (q[i] !== exp[i]) begin fails++; $display("FAIL b2b_sym%0d: got %h expected %h", i, q[i], exp[i]); end
    end
    tests++;
    if ({hold, overflow} !== 2'b01) begin fails++; $display("FAIL b2b_drained: got hold=%b ovf=%b expected hold=0 ovf=1", hold, overflow); end
  endtask

  task automatic test_stall();
    logic        prev_stall;
    logic [15:0] prev, now;
    rle_ready = 1'b0; q.delete(); exp.delete();
    clear_blk(); blk[0] = 9'd10; blk[63] = 9'd5;
    send_block();
    exp_dc63(9'd10, 9'd5);
    prev_stall = 1'b0; prev = 16'd0;
    for (int c = 0; c < 3000 && q.size() < exp.size(); c++) begin
      now = {rle_eob, rle_run, rle_level};
      if (prev_stall) begin
        tests++;
        if (rle_valid !== 1'b1 || now !== prev) begin
          fails++; $display("FAIL stall_stable: got v=%b %h expected v=1 %h", rle_valid, now, prev);
        end
      end
      rle_ready  = (c % 3 == 0);
      prev       = now;
      prev_stall = rle_valid && !rle_ready;
      tick();
    end
    rle_ready = 1'b1;
    repeat (8) tick();
    tests++;
    if (q.size() !== exp.size()) begin fails++; $display("FAIL stall_count: got %0d expected %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++;
      if (q[i] !== exp[i]) begin fails++; $display("FAIL stall_sym%0d: got %h expected %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    rle_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      dctq_valid = 1'b1; addr = 6'(i); dctq = 9'h011; tick();
    end
    dctq_valid = 1'b0; reset = 1'b1;
    tick();
    tests++;
    if (outs !== 19'd0) begin fails++; $display("FAIL midrst_outs: got %h expected 0", outs); end
    reset = 1'b0; q.delete(); exp.delete();
    tick();
    clear_blk(); blk[1] = 9'h1FF; blk[8] = 9'd3;
    send_block(); wait_syms(4);
    exp.push_back(sym(1'b0, 6'd0, 9'd0));
    exp.push_back(sym(1'b0, 6'd0, 9'h1FF));
    exp.push_back(sym(1'b0, 6'd0, 9'd3));
    exp.push_back(sym(1'b1, 6'd0, 9'd0));
    tests++;
    if (q.size() !== exp.size()) begin fails++; $display("FAIL midrst_count: got %0d expected %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++;
      if (q[i] !== exp[i]) begin fails++; $display("FAIL midrst_sym%0d: got %h expected %h", i, q[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_dc63();
    test_negative();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
